// File: rtl/heap_arbiter.sv
// heap_arbiter: shares the single-port heap RAM between requesters.
// Round-robin per beat, lockable grant, fixed-latency read return.
module heap_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      err_nil_wr
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t wrap_add(idx_t base, int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  idx_t              rr_ptr;
  idx_t              owner;
  logic              locked;
  logic              err_q;
  logic              pipe_vld [MEM_LAT];
  idx_t              pipe_id  [MEM_LAT];

  idx_t              win;
  logic              win_vld;
  logic              w_we;
  logic              w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              accept;
  logic              nil_wr;
  logic              rd_push;

  // Winner: owner while locked, else first valid from rr_ptr upward.
  always_comb begin
    win     = owner;
    win_vld = 1'b0;
    if (locked) begin
      win_vld = req_valid[owner];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(rr_ptr, k)]) begin
          win     = wrap_add(rr_ptr, k);
          win_vld = 1'b1;
        end
      end
    end
  end

  assign w_we    = req_we[win];
  assign w_lock  = req_lock[win];
  assign w_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign w_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];

  assign accept  = win_vld & ~rst;
  assign nil_wr  = accept & w_we & (w_addr == '0);
  assign rd_push = accept & ~w_we;

  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
  assign mem_en    = accept & ~nil_wr;
  assign mem_we    = mem_en & w_we;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

  assign err_nil_wr = err_q & ~rst;
  assign rsp_rdata  = mem_rdata;
  assign rsp_valid  = (pipe_vld[MEM_LAT-1] & ~rst)
                    ? (NUM_REQ'(1) << pipe_id[MEM_LAT-1]) : '0;

  // Round-robin pointer, lock ownership and NIL-write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      locked <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= nil_wr;
      if (accept) begin
        locked <= w_lock;
        if (w_lock) owner <= win;
        if (!locked || !w_lock) rr_ptr <= wrap_add(win, 1);
      end
    end
  end

  // Read-return pipe tracking which requester owns each RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_id[i]  <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_push;
      pipe_id[0]  <= win;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end
endmodule

// File: tb/tb_heap_arbiter.sv
// tb_heap_arbiter: directed bench, two DUTs (MEM_LAT 1 and 3)
// on shared stimulus, with RAM models and a read-return scoreboard.
module tb_heap_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv, rwe, rlk;
  logic [23:0] raddr;
  logic [15:0] rwd;

  logic [1:0]  rdy  [2];
  logic [1:0]  rsv  [2];
  logic [7:0]  rsd  [2];
  logic        men  [2];
  logic        mwe  [2];
  logic [11:0] madr [2];
  logic [7:0]  mwd  [2];
  logic [7:0]  mrd  [2];
  logic        err  [2];

  always #5 clk = ~clk;

  heap_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_ready(rdy[0]),
    .req_we(rwe), .req_lock(rlk),
    .req_addr(raddr), .req_wdata(rwd),
    .rsp_valid(rsv[0]), .rsp_rdata(rsd[0]),
    .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(madr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0]), .err_nil_wr(err[0])
  );

  heap_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_ready(rdy[1]),
    .req_we(rwe), .req_lock(rlk),
    .req_addr(raddr), .req_wdata(rwd),
    .rsp_valid(rsv[1]), .rsp_rdata(rsd[1]),
    .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(madr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1]), .err_nil_wr(err[1])
  );

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = i[7:0] ^ 8'h5A;
    if (i == 'h010) v = 8'h01;
    if (i == 0) v = 8'hA5;
    return v;
  endfunction

  // RAM models: 1-cycle and 3-cycle read latency
  logic [7:0] ram [2][4096];
  logic [7:0] rp  [2][3];
  logic       ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4096; i++) ram[d][i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (men[d] && mwe[d]) ram[d][madr[d]] <= mwd[d];
        if (men[d] && !mwe[d]) rp[d][0] <= ram[d][madr[d]];
        rp[d][1] <= rp[d][0];
        rp[d][2] <= rp[d][1];
      end
    end
  end

  assign mrd[0] = rp[0][0];
  assign mrd[1] = rp[1][2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] shadow [4096];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input logic v, input logic we,
                     input logic lk, input logic [11:0] a,
                     input logic [7:0] dt);
    rv[i]            = v;
    rwe[i]           = we;
    rlk[i]           = lk;
    raddr[i*12 +: 12] = a;
    rwd[i*8 +: 8]     = dt;
  endtask

  task automatic beat(input string tag, input logic [1:0] rdy_e,
                      input logic en_e, input logic we_e,
                      input logic [11:0] a_e, input logic [7:0] d_e);
    for (int d = 0; d < 2; d++) begin
      check({tag, "/ready"}, 32'(rdy[d]), 32'(rdy_e));
      check({tag, "/mem_en"}, 32'(men[d]), 32'(en_e));
      check({tag, "/mem_we"}, 32'(mwe[d]), 32'(we_e));
      if (en_e) check({tag, "/mem_addr"}, 32'(madr[d]), 32'(a_e));
      if (en_e && we_e)
        check({tag, "/mem_wdata"}, 32'(mwd[d]), 32'(d_e));
    end
  endtask

  task automatic chk_err(input string tag, input logic e_e);
    for (int d = 0; d < 2; d++)
      check({tag, "/err_nil_wr"}, 32'(err[d]), 32'(e_e));
  endtask

  task automatic exp_rd(input int id, input logic [11:0] a);
    exp_t e;
    e.id   = id;
    e.data = shadow[a];
    e.due  = cyc + 1;
    q0.push_back(e);
    e.due  = cyc + 3;
    q1.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      drv(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      #1;
      beat("idle", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    end
  endtask

  task automatic mon(input int d);
    exp_t       e;
    bit         hit;
    logic [1:0] oh;
    hit = 1'b0;
    if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      hit = 1'b1;
    end
    if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      hit = 1'b1;
    end
    if (hit) begin
      oh = (e.id == 0) ? 2'b01 : 2'b10;
      check($sformatf("rsp_valid[lat%0d]", d), 32'(rsv[d]), 32'(oh));
      check($sformatf("rsp_rdata[lat%0d]", d), 32'(rsd[d]), 32'(e.data));
    end else begin
      check($sformatf("rsp_idle[lat%0d]", d), 32'(rsv[d]), 32'(2'b00));
    end
  endtask

  // response scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) mon(d);
  end

  initial begin
    logic [11:0] a0, a1;
    int          w;
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);

    // reset: valid inputs must not be granted
    rst = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
    drv(1, 1'b1, 1'b0, 1'b0, 12'h020, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1;
    beat("reset", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    chk_err("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    drv(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #1;
    beat("post_reset", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);

    // single read by req0
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
    #1;
    beat("t1_rd", 2'b01, 1'b1, 1'b0, 12'h010, 8'h00);
    exp_rd(0, 12'h010);
    idle(4);

    // alternating grants after reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    beat("t2_rst", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat("t2_idle", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      a0 = 12'h020 + 12'(n);
      a1 = 12'h030 + 12'(n);
      drv(0, 1'b1, 1'b0, 1'b0, a0, 8'h00);
      drv(1, 1'b1, 1'b0, 1'b0, a1, 8'h00);
      #1;
      w = n % 2;
      beat("t2_rr", (w == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0,
           (w == 0) ? a0 : a1, 8'h00);
      exp_rd(w, (w == 0) ? a0 : a1);
    end
    idle(4);

    // locked three-beat cons write by req1 while req0 waits
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 12'h040, 8'h00);
    drv(1, 1'b1, 1'b1, 1'b1, 12'h100, 8'h01);
    #1;
    beat("t3_w0", 2'b10, 1'b1, 1'b1, 12'h100, 8'h01);
    shadow[12'h100] = 8'h01;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 1'b1, 12'h101, 8'h20);
    #1;
    beat("t3_w1", 2'b10, 1'b1, 1'b1, 12'h101, 8'h20);
    shadow[12'h101] = 8'h20;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 1'b0, 12'h102, 8'h00);
    #1;
    beat("t3_w2", 2'b10, 1'b1, 1'b1, 12'h102, 8'h00);
    shadow[12'h102] = 8'h00;
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 1'b0, 12'h100, 8'h00);
    #1;
    beat("t3_r0", 2'b01, 1'b1, 1'b0, 12'h040, 8'h00);
    exp_rd(0, 12'h040);
    @(negedge clk);
    #1;
    beat("t3_r1", 2'b10, 1'b1, 1'b0, 12'h100, 8'h00);
    exp_rd(1, 12'h100);
    idle(4);
    for (int d = 0; d < 2; d++)
      check("t3_ram101", 32'(ram[d][12'h101]), 32'(8'h20));

    // NIL write dropped and flagged; NIL read forwarded
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b0, 12'h000, 8'h55);
    #1;
    beat("t4_nil", 2'b01, 1'b0, 1'b0, 12'h000, 8'h00);
    chk_err("t4_pre", 1'b0);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
    #1;
    chk_err("t4_flag", 1'b1);
    beat("t4_rd", 2'b01, 1'b1, 1'b0, 12'h000, 8'h00);
    exp_rd(0, 12'h000);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #1;
    chk_err("t4_post", 1'b0);
    idle(4);
    for (int d = 0; d < 2; d++)
      check("t4_ram0", 32'(ram[d][0]), 32'(8'hA5));

    // owner drops valid while locked: everyone stalls
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b1, 12'h050, 8'h00);
    #1;
    beat("t5_lock", 2'b01, 1'b1, 1'b0, 12'h050, 8'h00);
    exp_rd(0, 12'h050);
    repeat (2) begin
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      drv(1, 1'b1, 1'b0, 1'b0, 12'h060, 8'h00);
      #1;
      beat("t5_stall", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    end
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 12'h051, 8'h00);
    #1;
    beat("t5_owner", 2'b01, 1'b1, 1'b0, 12'h051, 8'h00);
    exp_rd(0, 12'h051);
    @(negedge clk);
    #1;
    beat("t5_next", 2'b10, 1'b1, 1'b0, 12'h060, 8'h00);
    exp_rd(1, 12'h060);
    idle(4);

    // reset with a read in flight and the lock held
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 1'b1, 12'h070, 8'h00);
    #1;
    beat("t6_lock", 2'b10, 1'b1, 1'b0, 12'h070, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b0, 12'h080, 8'h00);
    drv(1, 1'b1, 1'b0, 1'b0, 12'h090, 8'h00);
    #1;
    beat("t6_rst", 2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    chk_err("t6_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat("t6_first", 2'b01, 1'b1, 1'b0, 12'h080, 8'h00);
    exp_rd(0, 12'h080);
    idle(5);

    check("q_lat1_empty", 32'(q0.size()), 32'(0));
    check("q_lat3_empty", 32'(q1.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
